// File: rtl/floor_call_dispatcher.sv
// Floor-call dispatcher: latches call buttons, picks the next stop by SCAN, times the door dwell.
// Latency: button -> pending on the 3rd edge, pending -> requested_floor one edge later; no backpressure.
module floor_call_dispatcher #(
    parameter int unsigned NUM_FLOORS  = 6,
    parameter logic [31:0] DWELL_COUNT = 32'd5000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] call_btn,
    input  logic [3:0]            current_floor,
    input  logic                  ctrl_idle,
    output logic [3:0]            requested_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  door_open,
    output logic                  dir_up
);

    typedef enum logic [1:0] {
        IDLE,
        MOVE,
        DOOR
    } state_t;

    state_t                state_q, state_d;
    logic [NUM_FLOORS-1:0] sync1_q, sync1_d;
    logic [NUM_FLOORS-1:0] sync2_q, sync2_d;
    logic [NUM_FLOORS-1:0] sync3_q, sync3_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [3:0]            req_q, req_d;
    logic                  door_q, door_d;
    logic                  dir_q, dir_d;
    logic [31:0]           dwell_q, dwell_d;

    logic [NUM_FLOORS-1:0] rise;
    logic [NUM_FLOORS-1:0] rise_keep;
    logic [NUM_FLOORS-1:0] clr;
    logic [NUM_FLOORS-1:0] cur_oh;
    logic                  cur_valid;
    logic                  hit_cur;
    logic                  above_found;
    logic [3:0]            above_lo;
    logic                  below_found;
    logic [3:0]            below_hi;
    logic [3:0]            sel_target;
    logic                  sel_dir;

    // Nearest pending floor on each side of the car, plus the SCAN choice.
    always_comb begin
        cur_oh      = '0;
        above_found = 1'b0;
        above_lo    = 4'd0;
        below_found = 1'b0;
        below_hi    = 4'd0;
        for (int i = int'(NUM_FLOORS) - 1; i >= 0; i--) begin
            cur_oh[i] = (current_floor == 4'(i));
            if (pending_q[i] && (4'(i) > current_floor)) begin
                above_found = 1'b1;
                above_lo    = 4'(i);
            end
        end
        for (int i = 0; i < int'(NUM_FLOORS); i++) begin
            if (pending_q[i] && (4'(i) < current_floor)) begin
                below_found = 1'b1;
                below_hi    = 4'(i);
            end
        end
        hit_cur   = |(pending_q & cur_oh);
        cur_valid = (current_floor < 4'(NUM_FLOORS));

        sel_target = current_floor;
        sel_dir    = dir_q;
        if (!hit_cur) begin
            if (dir_q) begin
                if (above_found) begin
                    sel_target = above_lo;
                end else begin
                    sel_target = below_hi;
                    sel_dir    = 1'b0;
                end
            end else begin
                if (below_found) begin
                    sel_target = below_hi;
                end else begin
                    sel_target = above_lo;
                    sel_dir    = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sync1_d   = call_btn;
        sync2_d   = sync1_q;
        sync3_d   = sync2_q;
        rise      = sync2_q & ~sync3_q;
        rise_keep = rise;
        clr       = '0;
        state_d   = state_q;
        req_d     = req_q;
        door_d    = door_q;
        dir_d     = dir_q;
        dwell_d   = dwell_q;

        case (state_q)
            IDLE: begin
                if (!cur_valid) begin
                    req_d = 4'd0;
                end else begin
                    req_d = current_floor;
                    if ((pending_q != '0) && ctrl_idle) begin
                        dir_d = sel_dir;
                        if (sel_target == current_floor) begin
                            state_d = DOOR;
                            door_d  = 1'b1;
                            dwell_d = 32'd0;
                            clr     = cur_oh;
                        end else begin
                            req_d   = sel_target;
                            state_d = MOVE;
                        end
                    end
                end
            end
            MOVE: begin
                if ((current_floor == req_q) && ctrl_idle) begin
                    state_d = DOOR;
                    door_d  = 1'b1;
                    dwell_d = 32'd0;
                    clr     = cur_oh;
                end else if (dir_q && above_found && (above_lo < req_q)) begin
                    req_d = above_lo;
                end else if (!dir_q && below_found && (below_hi > req_q)) begin
                    req_d = below_hi;
                end
            end
            DOOR: begin
                // A press at the open floor only holds the door; it never queues a call.
                rise_keep = rise & ~cur_oh;
                if (|(rise & cur_oh)) begin
                    dwell_d = 32'd0;
                end else if (dwell_q == (DWELL_COUNT - 32'd1)) begin
                    state_d = IDLE;
                    door_d  = 1'b0;
                    dwell_d = 32'd0;
                end else begin
                    dwell_d = dwell_q + 32'd1;
                end
            end
            default: begin
                state_d = IDLE;
                door_d  = 1'b0;
                dwell_d = 32'd0;
            end
        endcase

        pending_d = (pending_q | rise_keep) & ~clr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sync1_q   <= '0;
            sync2_q   <= '0;
            sync3_q   <= '0;
            pending_q <= '0;
            req_q     <= 4'd0;
            door_q    <= 1'b0;
            dir_q     <= 1'b1;
            dwell_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            sync3_q   <= sync3_d;
            pending_q <= pending_d;
            req_q     <= req_d;
            door_q    <= door_d;
            dir_q     <= dir_d;
            dwell_q   <= dwell_d;
        end
    end

    assign requested_floor = req_q;
    assign pending         = pending_q;
    assign door_open       = door_q;
    assign dir_up          = dir_q;

endmodule

// File: tb/tb_floor_call_dispatcher.sv
// Directed bench for floor_call_dispatcher with a behavioural car model (one floor per 8 clocks).
module tb_floor_call_dispatcher;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] call_btn = '0;
    logic [3:0] current_floor;
    logic       ctrl_idle = 1'b1;
    logic [3:0] requested_floor;
    logic [5:0] pending;
    logic       door_open;
    logic       dir_up;

    int errors = 0;
    int checks = 0;

    logic [3:0] pos = 4'd0;
    int         cnt = 0;
    logic       tp_en = 1'b0;
    logic [3:0] tp_pos = 4'd0;
    logic       force_cur = 1'b0;

    logic [3:0] door_log[$];
    logic       door_prev = 1'b0;
    int         door_len = 0;
    int         last_door_len = 0;

    always #5 clk = ~clk;

    assign current_floor = force_cur ? 4'd9 : pos;

    floor_call_dispatcher #(
        .NUM_FLOORS (6),
        .DWELL_COUNT(32'd4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .call_btn       (call_btn),
        .current_floor  (current_floor),
        .ctrl_idle      (ctrl_idle),
        .requested_floor(requested_floor),
        .pending        (pending),
        .door_open      (door_open),
        .dir_up         (dir_up)
    );

    // Car model: heads one floor at a time toward requested_floor, idle when there.
    always @(posedge clk) begin
        if (tp_en) begin
            pos <= tp_pos;
            cnt <= 0;
        end else if (!rst_n || force_cur) begin
            cnt <= 0;
        end else if (requested_floor != pos) begin
            ctrl_idle <= 1'b0;
            if (cnt == 7) begin
                cnt <= 0;
                pos <= (requested_floor > pos) ? pos + 4'd1 : pos - 4'd1;
            end else begin
                cnt <= cnt + 1;
            end
        end else begin
            ctrl_idle <= 1'b1;
            cnt <= 0;
        end
    end

    // Door monitor: logs the floor of each door opening and the length of the last dwell.
    always @(posedge clk) begin
        if (door_open && !door_prev) begin
            door_log.push_back(current_floor);
            door_len = 1;
        end else if (door_open) begin
            door_len = door_len + 1;
        end else if (door_prev) begin
            last_door_len = door_len;
        end
        door_prev = door_open;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_door(input logic want, input int max, input string tag);
        int n = 0;
        while (door_open !== want && n < max) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(door_open), 32'(want));
    endtask

    task automatic wait_log(input int want, input int max, input string tag);
        int n = 0;
        while (door_log.size() < want && n < max) begin
            @(negedge clk);
            n++;
        end
        check(tag, door_log.size(), want);
    endtask

    task automatic wait_req(input logic [3:0] want, input int max, input string tag);
        int n = 0;
        while (requested_floor !== want && n < max) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(requested_floor), 32'(want));
    endtask

    task automatic teleport(input logic [3:0] f);
        tp_pos = f;
        tp_en  = 1'b1;
        tick(1);
        tp_en  = 1'b0;
        tick(3);
    endtask

    task automatic pulse(input logic [5:0] btn);
        call_btn = btn;
        tick(2);
        call_btn = '0;
    endtask

    initial begin
        tick(2);
        check("rst_req", 32'(requested_floor), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_door", 32'(door_open), 0);
        check("rst_dir", 32'(dir_up), 1);
        rst_n = 1'b1;
        tick(3);

        // 1: single call to floor 3
        door_log.delete();
        call_btn = 6'b001000;
        tick(2);
        check("t1_pending_e2", 32'(pending), 0);
        call_btn = '0;
        tick(1);
        check("t1_pending_e3", 32'(pending), 32'b001000);
        tick(1);
        check("t1_req", 32'(requested_floor), 3);
        check("t1_dir", 32'(dir_up), 1);
        wait_door(1'b1, 200, "t1_door_opens");
        check("t1_arrive_floor", 32'(current_floor), 3);
        check("t1_pending_clr", 32'(pending), 0);
        wait_door(1'b0, 50, "t1_door_closes");
        tick(1);
        check("t1_door_len", last_door_len, 4);
        check("t1_pending_end", 32'(pending), 0);

        // Bring car back to 0 (heading down)
        pulse(6'b000001);
        wait_log(2, 200, "t2_prep_log");
        wait_door(1'b0, 50, "t2_prep_close");
        check("t2_prep_dir", 32'(dir_up), 0);
        tick(2);

        // 2: retarget to 2 while heading to 4
        door_log.delete();
        pulse(6'b010000);
        wait_req(4'd4, 20, "t2_req4");
        tick(2);
        call_btn = 6'b000100;
        tick(2);
        call_btn = '0;
        tick(2);
        check("t2_retarget", 32'(requested_floor), 2);
        check("t2_still_0", 32'(current_floor), 0);
        wait_log(2, 300, "t2_log_n");
        check("t2_stop_a", 32'(door_log[0]), 2);
        check("t2_stop_b", 32'(door_log[1]), 4);
        wait_door(1'b0, 50, "t2_close");
        tick(2);

        // 3: at 3 going up with calls at 1 and 5
        teleport(4'd3);
        check("t3_req_at3", 32'(requested_floor), 3);
        check("t3_dir", 32'(dir_up), 1);
        door_log.delete();
        call_btn = 6'b100010;
        tick(2);
        call_btn = '0;
        tick(1);
        check("t3_pending", 32'(pending), 32'b100010);
        tick(1);
        check("t3_req5", 32'(requested_floor), 5);
        check("t3_dir_up", 32'(dir_up), 1);
        wait_log(2, 300, "t3_log_n");
        check("t3_stop_a", 32'(door_log[0]), 5);
        check("t3_stop_b", 32'(door_log[1]), 1);
        wait_door(1'b0, 50, "t3_close");
        check("t3_dir_down", 32'(dir_up), 0);
        tick(2);

        // 4: press current floor, then re-press during dwell
        door_log.delete();
        call_btn = 6'b000010;
        tick(2);
        call_btn = '0;
        tick(1);
        check("t4_pending", 32'(pending), 32'b000010);
        tick(1);
        check("t4_door", 32'(door_open), 1);
        check("t4_pending_clr", 32'(pending), 0);
        check("t4_no_move", 32'(requested_floor), 1);
        call_btn = 6'b000010;
        tick(2);
        call_btn = '0;
        tick(2);
        check("t4_repress_pending", 32'(pending), 0);
        check("t4_door_held", 32'(door_open), 1);
        wait_door(1'b0, 50, "t4_close");
        tick(1);
        check("t4_door_len", last_door_len, 7);
        check("t4_log_n", door_log.size(), 1);
        tick(2);

        // 5: async reset mid-trip
        door_log.delete();
        call_btn = 6'b100100;
        tick(2);
        call_btn = '0;
        tick(1);
        check("t5_pending", 32'(pending), 32'b100100);
        tick(1);
        check("t5_req", 32'(requested_floor), 2);
        tick(3);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_req", 32'(requested_floor), 0);
        check("t5_rst_pending", 32'(pending), 0);
        check("t5_rst_door", 32'(door_open), 0);
        check("t5_rst_dir", 32'(dir_up), 1);
        tick(2);
        rst_n = 1'b1;
        tick(60);
        check("t5_no_dispatch", door_log.size(), 0);
        check("t5_pending_end", 32'(pending), 0);
        check("t5_req_stay", 32'(requested_floor), 32'(current_floor));

        // 6: button held for 50 clocks
        teleport(4'd4);
        door_log.delete();
        call_btn = 6'b000010;
        tick(3);
        check("t6_pending", 32'(pending), 32'b000010);
        tick(47);
        check("t6_log_n", door_log.size(), 1);
        check("t6_stop", 32'(door_log[0]), 1);
        check("t6_pending_held", 32'(pending), 0);
        call_btn = '0;
        tick(10);
        check("t6_pending_end", 32'(pending), 0);

        // Fault: out-of-range floor sends car home, calls retained
        door_log.delete();
        force_cur = 1'b1;
        tick(2);
        check("flt_req_home", 32'(requested_floor), 0);
        pulse(6'b001000);
        tick(2);
        check("flt_pending", 32'(pending), 32'b001000);
        tick(10);
        check("flt_req_hold", 32'(requested_floor), 0);
        check("flt_no_door", 32'(door_open), 0);
        force_cur = 1'b0;
        wait_log(1, 200, "flt_resume");
        check("flt_stop", 32'(door_log[0]), 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
